// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and defaults for the shared "101" serial pattern detector.
//   state_t      : arbiter FSM state encoding (IDLE / STREAM / REPORT)
//   DEF_PAT_W    : default pattern length in bits
//   DEF_PATTERN  : default pattern, first-received bit in the MSB
// Optional build macro used by seq_det_core: SEQDET_OVERLAP_EN
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int                   DEF_PAT_W   = 3;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 3'b101;

endpackage

// File: rtl/seq_det_core.sv
// -----------------------------------------------------------------------------
// seq_det_core
// Serial pattern detector: shift history + fill counter + saturating match
// counter. One bit is consumed per cycle with shift_en_i high.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear_i      : restart detection for a new frame (hist/fill/count -> 0)
//   shift_en_i   : accept bit_i this cycle
//   bit_i        : serial data bit
//   match_o      : this cycle's shift completes a pattern (combinational)
//   count_o      : matches seen so far in the frame (registered, saturating)
// Build macro SEQDET_OVERLAP_EN: when defined, matches may overlap (fill is
// kept on a match); otherwise fill restarts after every match.
// -----------------------------------------------------------------------------
import seq_det_pkg::*;

module seq_det_core #(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic             match_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], bit_i};
        // fill counts valid history bits and sticks at PAT_W
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        match_o    = shift_en_i && !clear_i &&
                     (hist_shift == PATTERN) && (fill_inc == FILL_FULL);

        hist_d  = hist_q;
        fill_d  = fill_q;
        count_d = count_q;

        if (clear_i) begin
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
        end else if (shift_en_i) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (match_o) begin
`ifdef SEQDET_OVERLAP_EN
                // keep the history valid so trailing bits can start a new match
                fill_d = fill_inc;
`else
                // consumed bits cannot be reused by the next match
                fill_d = '0;
`endif
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_det_arbiter.sv
// -----------------------------------------------------------------------------
// seq_det_arbiter
// Round-robin shares one serial pattern detector among NREQ framed bit
// streams. One requester owns the engine per frame; when the frame's last bit
// is accepted a one-cycle result record tagged with the requester id is
// emitted.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req_valid   : per requester, bit available / frame pending
//   req_bit     : per requester serial data bit
//   req_last    : per requester, current bit closes the frame
//   req_ready   : per requester accept strobe (one-hot or zero)
//   res_valid   : result strobe, one cycle
//   res_id      : requester that owned the reported frame
//   res_count   : matches in the frame (saturating)
//   res_hit     : res_count != 0
//   busy        : engine not idle
// Build macro SEQDET_OVERLAP_EN (in seq_det_core) selects overlapping matches.
// -----------------------------------------------------------------------------
import seq_det_pkg::*;

module seq_det_arbiter #(
    parameter int               NREQ    = 4,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               CNT_W   = 8,
    localparam int              ID_W    = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_bit,
    input  logic [NREQ-1:0]  req_last,
    output logic [NREQ-1:0]  req_ready,
    output logic             res_valid,
    output logic [ID_W-1:0]  res_id,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    output logic             busy
);

    state_t           state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  grant_q;
    logic             res_valid_q;
    logic [ID_W-1:0]  res_id_q;
    logic [CNT_W-1:0] res_count_q;
    logic             res_hit_q;

    logic             pick_found;
    logic [ID_W-1:0]  pick_id;
    logic [ID_W:0]    slot;
    logic [ID_W-1:0]  cand;

    logic             hs;
    logic             hs_bit;
    logic             hs_last;
    logic             core_clear;
    logic             core_match;
    logic [CNT_W-1:0] core_count;

    // First requester at or after rr_ptr in circular order. Scanning from the
    // farthest offset down lets the nearest valid one win without a break.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        slot       = '0;
        cand       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            slot = {1'b0, rr_ptr_q} + (ID_W + 1)'(i);
            if (slot >= (ID_W + 1)'(NREQ)) begin
                slot = slot - (ID_W + 1)'(NREQ);
            end
            cand = slot[ID_W-1:0];
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == STREAM) begin
            req_ready[grant_q] = req_valid[grant_q];
        end
    end

    assign hs         = (state_q == STREAM) && req_valid[grant_q];
    assign hs_bit     = req_bit[grant_q];
    assign hs_last    = req_last[grant_q];
    // Holding the engine cleared while idle guarantees each grant starts fresh.
    assign core_clear = (state_q == IDLE);

    seq_det_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .CNT_W   (CNT_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (core_clear),
        .shift_en_i (hs),
        .bit_i      (hs_bit),
        .match_o    (core_match),
        .count_o    (core_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_count_q <= '0;
            res_hit_q   <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_count_q <= '0;
            res_hit_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_id;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs && hs_last) begin
                        // The counter register has not yet absorbed a match on
                        // the final bit, so fold it into the snapshot here.
                        state_q     <= REPORT;
                        res_valid_q <= 1'b1;
                        res_id_q    <= grant_q;
                        res_count_q <= (core_match && (core_count != {CNT_W{1'b1}}))
                                       ? core_count + 1'b1 : core_count;
                        res_hit_q   <= core_match || (core_count != '0);
                    end
                end
                REPORT: begin
                    rr_ptr_q <= (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;
    assign res_hit   = res_hit_q;
    assign busy      = (state_q != IDLE);

endmodule
